// File: rtl/pu_or1k_pkg.sv
// pu_or1k_pkg: shared types and constants for the OR1K pipeline blocks.
package pu_or1k_pkg;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;

    localparam logic [31:0] ARB_PRIO_DATA = "DATA";
    localparam logic [31:0] ARB_PRIO_RR   = {16'h0, "RR"};

endpackage

// File: rtl/pu_or1k_bus_watchdog.sv
// pu_or1k_bus_watchdog: per-access cycle counter that flags when a granted
// access has waited TIMEOUT cycles; TIMEOUT=0 never expires.
module pu_or1k_bus_watchdog #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT);

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + TO_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expire_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/pu_or1k_bus_arbiter.sv
// pu_or1k_bus_arbiter: shares one Wishbone bus interface port between the
// fetch and load/store requesters, with burst locking and an access watchdog.
module pu_or1k_bus_arbiter
    import pu_or1k_pkg::*;
#(
    parameter logic [31:0] PRIORITY = ARB_PRIO_DATA,
    parameter int          TIMEOUT  = 255,
    parameter int          TO_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_req_i,
    input  logic [31:0] ibus_adr_i,
    input  logic        ibus_burst_i,
    output logic        ibus_ack_o,
    output logic        ibus_err_o,
    output logic [31:0] ibus_dat_o,
    input  logic        dbus_req_i,
    input  logic [31:0] dbus_adr_i,
    input  logic [31:0] dbus_dat_i,
    input  logic [3:0]  dbus_bsel_i,
    input  logic        dbus_we_i,
    input  logic        dbus_burst_i,
    output logic        dbus_ack_o,
    output logic        dbus_err_o,
    output logic [31:0] dbus_dat_o,
    output logic        cpu_req_o,
    output logic [31:0] cpu_adr_o,
    output logic [31:0] cpu_dat_o,
    output logic [3:0]  cpu_bsel_o,
    output logic        cpu_we_o,
    output logic        cpu_burst_o,
    input  logic        cpu_ack_i,
    input  logic        cpu_err_i,
    input  logic [31:0] cpu_dat_i
);

    localparam bit PRIO_RR = (PRIORITY == ARB_PRIO_RR);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;  // 1 = data port held the last grant
    logic       gnt_i, gnt_d, sel_req, sel_burst;
    logic       wd_hit, timeout, release_gnt;

    assign gnt_i     = state_q == GNT_I;
    assign gnt_d     = state_q == GNT_D;
    assign sel_req   = (gnt_i && ibus_req_i) || (gnt_d && dbus_req_i);
    assign sel_burst = (gnt_i && ibus_burst_i) || (gnt_d && dbus_burst_i);

    // An ack landing on the expiry cycle completes the access instead.
    assign timeout     = wd_hit && !cpu_ack_i;
    assign release_gnt = !sel_req || cpu_err_i || timeout || (cpu_ack_i && !sel_burst);

    pu_or1k_bus_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE || cpu_ack_i),
        .en_i     (!cpu_err_i),
        .expire_o (wd_hit)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (ibus_req_i && dbus_req_i) state_d = (PRIO_RR && last_grant_q) ? GNT_I : GNT_D;
            else if (dbus_req_i)          state_d = GNT_D;
            else if (ibus_req_i)          state_d = GNT_I;
        end else if (release_gnt) begin
            state_d      = IDLE;
            last_grant_d = gnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cpu_req_o   = sel_req && !wd_hit;
    assign cpu_adr_o   = gnt_d ? dbus_adr_i : gnt_i ? ibus_adr_i : '0;
    assign cpu_dat_o   = gnt_d ? dbus_dat_i : '0;
    assign cpu_bsel_o  = gnt_d ? dbus_bsel_i : gnt_i ? 4'hF : 4'h0;
    assign cpu_we_o    = gnt_d && dbus_we_i;
    assign cpu_burst_o = sel_burst;

    assign ibus_ack_o = gnt_i && cpu_ack_i && !cpu_err_i;
    assign ibus_err_o = gnt_i && (cpu_err_i || timeout);
    assign ibus_dat_o = gnt_i ? cpu_dat_i : '0;
    assign dbus_ack_o = gnt_d && cpu_ack_i && !cpu_err_i;
    assign dbus_err_o = gnt_d && (cpu_err_i || timeout);
    assign dbus_dat_o = gnt_d ? cpu_dat_i : '0;

endmodule

// File: tb/tb_pu_or1k_bus_arbiter.sv
// tb_pu_or1k_bus_arbiter: directed checks of the bus arbiter, one DATA-priority
// instance with an 8-cycle watchdog and one round-robin instance.
module tb_pu_or1k_bus_arbiter;
    import pu_or1k_pkg::*;

    logic clk = 1'b0, rst = 1'b0, rst_rr = 1'b0;
    logic ibus_req_i = 1'b0, ibus_burst_i = 1'b0;
    logic [31:0] ibus_adr_i = '0;
    logic dbus_req_i = 1'b0, dbus_we_i = 1'b0, dbus_burst_i = 1'b0;
    logic [31:0] dbus_adr_i = '0, dbus_dat_i = '0;
    logic [3:0] dbus_bsel_i = 4'hF;
    logic cpu_ack_i = 1'b0, cpu_err_i = 1'b0;
    logic [31:0] cpu_dat_i = '0;

    logic ibus_ack_o, ibus_err_o, dbus_ack_o, dbus_err_o, cpu_req_o, cpu_we_o, cpu_burst_o;
    logic [31:0] ibus_dat_o, dbus_dat_o, cpu_adr_o, cpu_dat_o;
    logic [3:0] cpu_bsel_o;
    logic r_ibus_ack_o, r_ibus_err_o, r_dbus_ack_o, r_dbus_err_o, r_cpu_req_o, r_cpu_we_o, r_cpu_burst_o;
    logic [31:0] r_ibus_dat_o, r_dbus_dat_o, r_cpu_adr_o, r_cpu_dat_o;
    logic [3:0] r_cpu_bsel_o;

    logic [138:0] dut_outs, rr_outs;
    assign dut_outs = {ibus_ack_o, ibus_err_o, ibus_dat_o, dbus_ack_o, dbus_err_o, dbus_dat_o,
                       cpu_req_o, cpu_adr_o, cpu_dat_o, cpu_bsel_o, cpu_we_o, cpu_burst_o};
    assign rr_outs  = {r_ibus_ack_o, r_ibus_err_o, r_ibus_dat_o, r_dbus_ack_o, r_dbus_err_o, r_dbus_dat_o,
                       r_cpu_req_o, r_cpu_adr_o, r_cpu_dat_o, r_cpu_bsel_o, r_cpu_we_o, r_cpu_burst_o};

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    pu_or1k_bus_arbiter #(.PRIORITY(ARB_PRIO_DATA), .TIMEOUT(8), .TO_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i), .ibus_burst_i(ibus_burst_i),
        .ibus_ack_o(ibus_ack_o), .ibus_err_o(ibus_err_o), .ibus_dat_o(ibus_dat_o),
        .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
        .dbus_bsel_i(dbus_bsel_i), .dbus_we_i(dbus_we_i), .dbus_burst_i(dbus_burst_i),
        .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o), .dbus_dat_o(dbus_dat_o),
        .cpu_req_o(cpu_req_o), .cpu_adr_o(cpu_adr_o), .cpu_dat_o(cpu_dat_o),
        .cpu_bsel_o(cpu_bsel_o), .cpu_we_o(cpu_we_o), .cpu_burst_o(cpu_burst_o),
        .cpu_ack_i(cpu_ack_i), .cpu_err_i(cpu_err_i), .cpu_dat_i(cpu_dat_i)
    );

    pu_or1k_bus_arbiter #(.PRIORITY(ARB_PRIO_RR), .TIMEOUT(0), .TO_WIDTH(8)) u_rr (
        .clk(clk), .rst(rst_rr),
        .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i), .ibus_burst_i(ibus_burst_i),
        .ibus_ack_o(r_ibus_ack_o), .ibus_err_o(r_ibus_err_o), .ibus_dat_o(r_ibus_dat_o),
        .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
        .dbus_bsel_i(dbus_bsel_i), .dbus_we_i(dbus_we_i), .dbus_burst_i(dbus_burst_i),
        .dbus_ack_o(r_dbus_ack_o), .dbus_err_o(r_dbus_err_o), .dbus_dat_o(r_dbus_dat_o),
        .cpu_req_o(r_cpu_req_o), .cpu_adr_o(r_cpu_adr_o), .cpu_dat_o(r_cpu_dat_o),
        .cpu_bsel_o(r_cpu_bsel_o), .cpu_we_o(r_cpu_we_o), .cpu_burst_o(r_cpu_burst_o),
        .cpu_ack_i(cpu_ack_i), .cpu_err_i(cpu_err_i), .cpu_dat_i(cpu_dat_i)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        cpu_dat_i = 32'hDEADBEEF; ibus_req_i = 1'b1; dbus_req_i = 1'b1;
        cyc(); #1;
        tests++; if (dut_outs !== '0) begin fails++; $display("FAIL reset_outs: got %h want 0", dut_outs); end
        tests++; if (rr_outs !== '0) begin fails++; $display("FAIL reset_rr_outs: got %h want 0", rr_outs); end
        ibus_req_i = 1'b0; dbus_req_i = 1'b0; cpu_dat_i = '0; rst = 1'b1;
        cyc(); #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL reset_idle_req: got %b want 0", cpu_req_o); end
    endtask

    task automatic test_single_read();
        cyc();
        dbus_req_i = 1'b1; dbus_adr_i = 32'h100; dbus_we_i = 1'b0; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL rd_req_idle: got %b want 0", cpu_req_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, cpu_adr_o} !== {1'b1, 32'h100}) begin fails++; $display("FAIL rd_req_rise: got %b/%h want 1/100", cpu_req_o, cpu_adr_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, dbus_ack_o} !== 2'b10) begin fails++; $display("FAIL rd_wait: got req/ack %b%b want 10", cpu_req_o, dbus_ack_o); end
        cyc(); cpu_ack_i = 1'b1; cpu_dat_i = 32'hDEADBEEF; #1;
        tests++; if ({dbus_ack_o, ibus_ack_o} !== 2'b10) begin fails++; $display("FAIL rd_ack: got d/i ack %b%b want 10", dbus_ack_o, ibus_ack_o); end
        tests++; if ({dbus_dat_o, ibus_dat_o} !== {32'hDEADBEEF, 32'h0}) begin fails++; $display("FAIL rd_data: got d=%h i=%h want deadbeef/0", dbus_dat_o, ibus_dat_o); end
        cyc(); cpu_ack_i = 1'b0; dbus_req_i = 1'b0; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL rd_idle_after: got %b want 0", cpu_req_o); end
    endtask

    task automatic test_priority_data();
        cyc();
        ibus_req_i = 1'b1; ibus_adr_i = 32'h300;
        dbus_req_i = 1'b1; dbus_adr_i = 32'h400; dbus_we_i = 1'b1; dbus_dat_i = 32'h55AA; #1;
        cyc(); #1;
        tests++; if ({cpu_req_o, cpu_adr_o, cpu_we_o, cpu_dat_o} !== {1'b1, 32'h400, 1'b1, 32'h55AA}) begin
            fails++; $display("FAIL prio_data_first: got req=%b adr=%h we=%b dat=%h want 1/400/1/55aa", cpu_req_o, cpu_adr_o, cpu_we_o, cpu_dat_o); end
        cpu_ack_i = 1'b1; #1;
        tests++; if ({dbus_ack_o, ibus_ack_o} !== 2'b10) begin fails++; $display("FAIL prio_data_ack: got d/i %b%b want 10", dbus_ack_o, ibus_ack_o); end
        cyc(); cpu_ack_i = 1'b0; dbus_req_i = 1'b0; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL prio_idle_gap: got %b want 0", cpu_req_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, cpu_adr_o, cpu_bsel_o, cpu_we_o, cpu_dat_o} !== {1'b1, 32'h300, 4'hF, 1'b0, 32'h0}) begin
            fails++; $display("FAIL prio_ibus_next: got req=%b adr=%h bsel=%h we=%b dat=%h want 1/300/f/0/0", cpu_req_o, cpu_adr_o, cpu_bsel_o, cpu_we_o, cpu_dat_o); end
        cpu_ack_i = 1'b1; #1;
        tests++; if ({ibus_ack_o, dbus_ack_o} !== 2'b10) begin fails++; $display("FAIL prio_ibus_ack: got i/d %b%b want 10", ibus_ack_o, dbus_ack_o); end
        cyc(); cpu_ack_i = 1'b0; ibus_req_i = 1'b0; dbus_we_i = 1'b0; dbus_dat_i = '0;
    endtask

    task automatic test_burst();
        cyc();
        ibus_req_i = 1'b1; ibus_burst_i = 1'b1; ibus_adr_i = 32'h200;
        cyc();
        dbus_req_i = 1'b1; dbus_adr_i = 32'h500;
        for (int b = 0; b < 4; b++) begin
            ibus_adr_i = 32'h200 + 32'(4 * b); ibus_burst_i = (b < 3); cpu_ack_i = 1'b1; #1;
            tests++; if ({cpu_req_o, cpu_adr_o, ibus_ack_o, dbus_ack_o} !== {1'b1, 32'h200 + 32'(4 * b), 2'b10}) begin
                fails++; $display("FAIL burst_beat%0d: got req=%b adr=%h i/d ack=%b%b want 1/%h/10", b, cpu_req_o, cpu_adr_o, ibus_ack_o, dbus_ack_o, 32'h200 + 32'(4 * b)); end
            cyc();
        end
        cpu_ack_i = 1'b0; ibus_req_i = 1'b0; ibus_burst_i = 1'b0; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL burst_idle_gap: got %b want 0", cpu_req_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, cpu_adr_o} !== {1'b1, 32'h500}) begin fails++; $display("FAIL burst_dbus_after: got %b/%h want 1/500", cpu_req_o, cpu_adr_o); end
        cpu_ack_i = 1'b1;
        cyc(); cpu_ack_i = 1'b0; dbus_req_i = 1'b0;
    endtask

    task automatic test_timeout();
        cyc();
        ibus_req_i = 1'b1; ibus_adr_i = 32'h600;
        cyc();
        for (int k = 0; k < 8; k++) begin
            #1;
            tests++; if ({cpu_req_o, ibus_err_o} !== 2'b10) begin fails++; $display("FAIL to_wait%0d: got req/err %b%b want 10", k, cpu_req_o, ibus_err_o); end
            cyc();
        end
        #1;
        tests++; if ({cpu_req_o, ibus_err_o, ibus_ack_o} !== 3'b010) begin fails++; $display("FAIL to_expire: got req/err/ack %b%b%b want 010", cpu_req_o, ibus_err_o, ibus_ack_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, ibus_err_o} !== 2'b00) begin fails++; $display("FAIL to_idle: got req/err %b%b want 00", cpu_req_o, ibus_err_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, ibus_err_o} !== 2'b10) begin fails++; $display("FAIL to_regrant: got req/err %b%b want 10", cpu_req_o, ibus_err_o); end
        ibus_req_i = 1'b0;
    endtask

    task automatic test_ack_err_abort();
        cyc();
        dbus_req_i = 1'b1; dbus_adr_i = 32'h700;
        cyc(); cpu_ack_i = 1'b1; cpu_err_i = 1'b1; #1;
        tests++; if ({dbus_err_o, dbus_ack_o, ibus_err_o, ibus_ack_o} !== 4'b1000) begin
            fails++; $display("FAIL ack_err: got d err/ack i err/ack %b%b%b%b want 1000", dbus_err_o, dbus_ack_o, ibus_err_o, ibus_ack_o); end
        cyc(); cpu_ack_i = 1'b0; cpu_err_i = 1'b0; dbus_req_i = 1'b0; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL ack_err_idle: got %b want 0", cpu_req_o); end
        cyc(); dbus_req_i = 1'b1;
        cyc(); #1;
        tests++; if (cpu_req_o !== 1'b1) begin fails++; $display("FAIL abort_granted: got %b want 1", cpu_req_o); end
        cyc(); dbus_req_i = 1'b0; ibus_req_i = 1'b1; ibus_adr_i = 32'h800; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL abort_drop: got %b want 0", cpu_req_o); end
        cyc(); #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b want 0", cpu_req_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, cpu_adr_o} !== {1'b1, 32'h800}) begin fails++; $display("FAIL abort_next_grant: got %b/%h want 1/800", cpu_req_o, cpu_adr_o); end
        cpu_ack_i = 1'b1;
        cyc(); cpu_ack_i = 1'b0; ibus_req_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        cyc();
        dbus_req_i = 1'b1; dbus_adr_i = 32'h900; cpu_dat_i = 32'hCAFEF00D;
        cyc(); #1;
        tests++; if (cpu_req_o !== 1'b1) begin fails++; $display("FAIL rstmid_granted: got %b want 1", cpu_req_o); end
        cyc(); rst = 1'b0; #1;
        tests++; if (dut_outs !== '0) begin fails++; $display("FAIL rstmid_outs: got %h want 0", dut_outs); end
        rst = 1'b1; #1;
        tests++; if (cpu_req_o !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got %b want 0", cpu_req_o); end
        cyc(); #1;
        tests++; if ({cpu_req_o, cpu_adr_o} !== {1'b1, 32'h900}) begin fails++; $display("FAIL rstmid_regrant: got %b/%h want 1/900", cpu_req_o, cpu_adr_o); end
        dbus_req_i = 1'b0; cpu_dat_i = '0;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_adr;
        rst = 1'b0; rst_rr = 1'b1;
        cyc();
        ibus_req_i = 1'b1; ibus_adr_i = 32'hA00; dbus_req_i = 1'b1; dbus_adr_i = 32'hB00;
        for (int g = 0; g < 3; g++) begin
            exp_adr = (g == 1) ? 32'hA00 : 32'hB00;
            cyc(); #1;
            tests++; if ({r_cpu_req_o, r_cpu_adr_o} !== {1'b1, exp_adr}) begin fails++; $display("FAIL rr_grant%0d: got %b/%h want 1/%h", g, r_cpu_req_o, r_cpu_adr_o, exp_adr); end
            cpu_ack_i = 1'b1; #1;
            tests++; if ({r_ibus_ack_o, r_dbus_ack_o} !== ((g == 1) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL rr_ack%0d: got i/d %b%b want %b", g, r_ibus_ack_o, r_dbus_ack_o, (g == 1) ? 2'b10 : 2'b01); end
            cyc(); cpu_ack_i = 1'b0; #1;
            tests++; if (r_cpu_req_o !== 1'b0) begin fails++; $display("FAIL rr_idle%0d: got %b want 0", g, r_cpu_req_o); end
        end
        rst_rr = 1'b0; #1;
        rst_rr = 1'b1;
        cyc(); #1;
        tests++; if ({r_cpu_req_o, r_cpu_adr_o} !== {1'b1, 32'hB00}) begin fails++; $display("FAIL rr_after_reset: got %b/%h want 1/b00", r_cpu_req_o, r_cpu_adr_o); end
        cpu_ack_i = 1'b1;
        cyc(); cpu_ack_i = 1'b0; ibus_req_i = 1'b0; dbus_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_data();
        test_burst();
        test_timeout();
        test_ack_err_abort();
        test_reset_mid();
        test_round_robin();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pu_or1k_bus_arbiter.md
Name: pu_or1k_bus_arbiter

Overview:
Two-master arbiter that shares one single-master Wishbone bus interface port between the instruction-fetch and data (load/store) requesters of the OR1K pipeline. It sits between the fetch/LSU units and the Wishbone bus interface block. It exposes the same cpu_* request/ack/err handshake upstream (two copies) and downstream (one copy). It adds grant locking for bursts, selectable priority, and a per-access watchdog that converts a hung slave into an error.

Parameters:
PRIORITY, "DATA", arbitration policy: "DATA" = data port always wins ties; "RR" = round-robin, tie goes to the port not granted last
TIMEOUT, 255, cycles a granted access may wait for ack/err before the arbiter aborts it; 0 disables the watchdog
TO_WIDTH, 8, width of the watchdog counter; must satisfy TIMEOUT < 2^TO_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
ibus_req_i  in  1  fetch request, held until ack/err
ibus_adr_i  in  32  fetch address
ibus_burst_i  in  1  fetch wants further beats after this one
ibus_ack_o  out  1  fetch beat done
ibus_err_o  out  1  fetch bus error or timeout
ibus_dat_o  out  32  fetch read data
dbus_req_i  in  1  data request, held until ack/err
dbus_adr_i  in  32  data address
dbus_dat_i  in  32  store data
dbus_bsel_i  in  4  byte selects
dbus_we_i  in  1  write enable
dbus_burst_i  in  1  data burst continue
dbus_ack_o  out  1  data beat done
dbus_err_o  out  1  data bus error or timeout
dbus_dat_o  out  32  load data
cpu_req_o, cpu_adr_o[32], cpu_dat_o[32], cpu_bsel_o[4], cpu_we_o, cpu_burst_o  out  downstream request to bus interface
cpu_ack_i, cpu_err_i, cpu_dat_i[32]  in  downstream response

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, last_grant=IBUS, watchdog=0. All *_o are 0. This holds even mid-transfer; the downstream request drops in the same instant.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Sample the requests. No request → stay in IDLE.
  - One request → that port's GNT state.
  - Both requests, PRIORITY="DATA" → GNT_D.
  - Both requests, PRIORITY="RR" → grant the port opposite last_grant.
  - The decision is registered, so the first downstream cpu_req_o is asserted 1 cycle after the upstream req is seen in IDLE.
- GNT_x:
  - Mux the granted port onto cpu_*_o combinationally; the ungranted port sees ack/err = 0.
  - For ibus: cpu_bsel_o=4'hF, cpu_we_o=0, cpu_dat_o=0.
  - cpu_ack_i, cpu_err_i and cpu_dat_i are routed combinationally to the granted port. dat_o is 0 on the other port.
- Release from GNT_x to IDLE (last_grant := x) occurs on any of:
  - cpu_ack_i with x_burst_i=0;
  - cpu_err_i;
  - x_req_i=0 (requester abort; cpu_req_o drops the same cycle);
  - watchdog expiry.
- With x_burst_i=1, ack keeps the grant: the next beat follows with no IDLE bubble, and the other port waits even if requesting.
- After every release there is exactly 1 IDLE cycle. cpu_req_o is 0 in that cycle, which guarantees the downstream cycle_end/STB de-assertion.
- Watchdog:
  - Counter clears on entering GNT and on every cpu_ack_i.
  - It increments on each GNT cycle without ack/err.
  - When it equals TIMEOUT (TIMEOUT≠0): assert x_err_o for that single cycle with cpu_req_o forced to 0, then go to IDLE.
  - Simultaneous cpu_ack_i and timeout: the ack wins and the counter clears.
- Simultaneous cpu_ack_i and cpu_err_i: err takes precedence. The requester sees err=1, ack=0.
- A new request arriving in the release cycle is sampled in the following IDLE cycle, never in GNT.
- RR fairness: with both ports continuously requesting non-burst beats, grants strictly alternate.

Decomposition:
- Shared package pu_or1k_pkg gains:
  - the enum arb_state_t {IDLE, GNT_I, GNT_D};
  - the localparam ARB_PRIO_DATA/ARB_PRIO_RR strings.
- One natural sub-module, pu_or1k_bus_watchdog: counter with clear, enable and TIMEOUT compare, producing an expire pulse.
- The grant FSM and the muxes stay in the top module.

Test Plan:
- dbus single read at 0x100. Required: cpu_req_o rises 1 cycle after dbus_req_i; slave acks with 0xDEADBEEF 2 cycles later → dbus_ack_o=1, dbus_dat_o=0xDEADBEEF, ibus_ack_o=0; 1 IDLE cycle follows with cpu_req_o=0.
- Both ports request in the same cycle, PRIORITY="DATA". Required: GNT_D first; ibus is granted only after the dbus ack plus 1 IDLE cycle. With PRIORITY="RR" and last_grant=DBUS, ibus wins.
- ibus 4-beat burst from 0x200 (burst_i=1 for 3 beats) while dbus requests. Required: 4 consecutive ibus acks with no IDLE gap; dbus is granted only after beat 4.
- TIMEOUT=8, slave never acks. Required: ibus_err_o=1 exactly 8 granted cycles after the grant, cpu_req_o=0 that cycle, state returns to IDLE.
- cpu_ack_i and cpu_err_i asserted together. Required: err=1, ack=0 to the granted port. dbus_req_i dropped mid-access. Required: cpu_req_o drops the same cycle and the grant is released.
- rst driven low during a GNT_D wait state. Required: all outputs 0 asynchronously; after rst=1 the FSM is in IDLE and last_grant=IBUS.
